// File: rtl/elevador_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | elevador_pkg : shared types and constants for the floor tracker      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package elevador_pkg;

    localparam int DEFAULT_FLOOR_W = 3;

    typedef enum logic [1:0] {
        TRK_INIT  = 2'd0,
        TRK_TRACK = 2'd1,
        TRK_FAULT = 2'd2
    } trk_state_t;

endpackage
`default_nettype wire

// File: rtl/gray2bin_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray2bin_n : combinational WIDTH-bit Gray to binary decoder          |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module gray2bin_n #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_bin
);

    // Each binary bit is the XOR of all Gray bits at or above it, which
    // flattens the serial chain bin[i] = bin[i+1] ^ g[i].
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign o_bin[i] = ^i_gray[WIDTH-1:i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/gray_floor_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_floor_tracker : sync, debounce and step-check a Gray floor code |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module gray_floor_tracker
    import elevador_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_FLOOR_W,
    parameter int DEBOUNCE  = 4,
    parameter int MAX_FLOOR = 2**WIDTH-1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] gray_i,
    input  logic             clear_err_i,
    output logic [WIDTH-1:0] floor_o,
    output logic             valid_o,
    output logic             moved_o,
    output logic             dir_up_o,
    output logic             dir_dn_o,
    output logic             err_o
);

    localparam int               CNT_W  = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] c_deb  = CNT_W'(DEBOUNCE);
    localparam logic [WIDTH:0]   c_max  = (WIDTH+1)'(MAX_FLOOR);
    localparam logic [WIDTH:0]   c_one  = (WIDTH+1)'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_stable;
    logic [WIDTH-1:0] w_bin;
    logic [WIDTH:0]   w_new_x;
    logic [WIDTH:0]   w_old_x;
    logic             w_over;
    logic             w_up;
    logic             w_dn;
    trk_state_t       r_state;

    logic [WIDTH-1:0] r_floor;
    logic             r_valid;
    logic             r_moved;
    logic             r_up;
    logic             r_dn;
    logic             r_err;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= gray_i;
            r_sync2 <= r_sync1;
        end
    end

    // Comparing the incoming sync1 against sync2 lets the stable decision
    // be taken on the edge the count reaches DEBOUNCE, not one later.
    always_comb begin
        w_cnt_next = r_cnt;
        if (r_sync1 != r_sync2) begin
            w_cnt_next = '0;
        end else if (r_cnt != c_deb) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    assign w_stable = enable_i && (w_cnt_next == c_deb);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (enable_i) begin
            r_cnt <= w_cnt_next;
        end
    end

    gray2bin_n #(
        .WIDTH (WIDTH)
    ) u_g2b (
        .i_gray (r_sync2),
        .o_bin  (w_bin)
    );

    // One extra bit keeps MAX_FLOOR -> 0 from looking like an upward step.
    assign w_new_x = {1'b0, w_bin};
    assign w_old_x = {1'b0, r_floor};
    assign w_over  = (w_new_x > c_max);
    assign w_up    = !w_over && (w_new_x == w_old_x + c_one);
    assign w_dn    = !w_over && (w_old_x == w_new_x + c_one);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= TRK_INIT;
            r_floor <= '0;
            r_valid <= 1'b0;
            r_moved <= 1'b0;
            r_up    <= 1'b0;
            r_dn    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_moved <= 1'b0;
            if (enable_i) begin
                case (r_state)
                    TRK_INIT: begin
                        if (w_stable) begin
                            if (w_over) begin
                                r_err   <= 1'b1;
                                r_state <= TRK_FAULT;
                            end else begin
                                r_floor <= w_bin;
                                r_valid <= 1'b1;
                                r_state <= TRK_TRACK;
                            end
                        end
                    end
                    TRK_TRACK: begin
                        if (w_stable && (w_bin != r_floor)) begin
                            if (w_up || w_dn) begin
                                r_floor <= w_bin;
                                r_moved <= 1'b1;
                                r_up    <= w_up;
                                r_dn    <= w_dn;
                            end else begin
                                r_valid <= 1'b0;
                                r_err   <= 1'b1;
                                r_state <= TRK_FAULT;
                            end
                        end
                    end
                    TRK_FAULT: begin
                        if (clear_err_i) begin
                            r_err   <= 1'b0;
                            r_up    <= 1'b0;
                            r_dn    <= 1'b0;
                            r_state <= TRK_INIT;
                        end
                    end
                    default: r_state <= TRK_INIT;
                endcase
            end
        end
    end

    assign floor_o  = r_floor;
    assign valid_o  = r_valid;
    assign moved_o  = r_moved;
    assign dir_up_o = r_up;
    assign dir_dn_o = r_dn;
    assign err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gray_floor_tracker.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gray_floor_tracker : scoreboard bench for gray_floor_tracker      |
// | Revision              : 1.0                                          |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_gray_floor_tracker;

    localparam int W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n_a, en_a, clr_a;
    logic [W-1:0] g_a;
    logic [W-1:0] floor_a;
    logic         valid_a, moved_a, up_a, dn_a, err_a;

    logic         rst_n_b, en_b, clr_b;
    logic [W-1:0] g_b;
    logic [W-1:0] floor_b;
    logic         valid_b, moved_b, up_b, dn_b, err_b;

    gray_floor_tracker #(.WIDTH(W), .DEBOUNCE(4), .MAX_FLOOR(7)) dut_a (
        .clk_i       (clk),
        .rst_n_i     (rst_n_a),
        .enable_i    (en_a),
        .gray_i      (g_a),
        .clear_err_i (clr_a),
        .floor_o     (floor_a),
        .valid_o     (valid_a),
        .moved_o     (moved_a),
        .dir_up_o    (up_a),
        .dir_dn_o    (dn_a),
        .err_o       (err_a)
    );

    gray_floor_tracker #(.WIDTH(W), .DEBOUNCE(4), .MAX_FLOOR(5)) dut_b (
        .clk_i       (clk),
        .rst_n_i     (rst_n_b),
        .enable_i    (en_b),
        .gray_i      (g_b),
        .clear_err_i (clr_b),
        .floor_o     (floor_b),
        .valid_o     (valid_b),
        .moved_o     (moved_b),
        .dir_up_o    (up_b),
        .dir_dn_o    (dn_b),
        .err_o       (err_b)
    );

    typedef struct packed {
        logic [W-1:0] floor;
        logic         valid;
        logic         up;
        logic         dn;
        logic         err;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Drive a new code, expect one moved_o pulse carrying exp; exp_lat > 0
    // also checks the edge count from the code change to the pulse.
    task automatic step_a(input logic [W-1:0] code, input logic [W-1:0] floor,
                          input logic up, input logic dn, input int exp_lat,
                          input string name);
        exp_t e, got;
        int   lat;
        bit   seen;
        e.floor = floor; e.valid = 1'b1; e.up = up; e.dn = dn; e.err = 1'b0;
        sb_q.push_back(e);
        g_a  = code;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 12 && !seen; i++) begin
            @(negedge clk);
            if (moved_a === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: no moved_o pulse within 12 cycles, required one", name);
            sb_q.delete();
        end else begin
            got = {floor_a, valid_a, up_a, dn_a, err_a};
            e   = sb_q.pop_front();
            if (got !== e) begin
                n_err++;
                $display("FAIL %s: {floor,valid,up,dn,err} got %b required %b", name, got, e);
            end
            if (exp_lat > 0) begin
                n_vec++;
                if (lat !== exp_lat) begin
                    n_err++;
                    $display("FAIL %s_latency: got %0d edges required %0d", name, lat, exp_lat);
                end
            end
            @(negedge clk);
            n_vec++;
            if (moved_a !== 1'b0) begin
                n_err++;
                $display("FAIL %s_pulse_width: moved_o got %b required 0", name, moved_a);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        int moves;
        rst_n_a = 1'b0; en_a = 1'b1; clr_a = 1'b0; g_a = 3'b000;
        rst_n_b = 1'b0; en_b = 1'b1; clr_b = 1'b0; g_b = 3'b111;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({floor_a, valid_a, moved_a, up_a, dn_a, err_a} !== 8'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 00000000",
                     {floor_a, valid_a, moved_a, up_a, dn_a, err_a});
        end
        rst_n_a = 1'b1;
        moves = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (moved_a === 1'b1) moves++;
        end
        n_vec++;
        if ({floor_a, valid_a, up_a, dn_a, err_a, moves[0]} !== {3'd0, 1'b1, 4'b0} || moves != 0) begin
            n_err++;
            $display("FAIL init_load: floor=%0d valid=%b up=%b dn=%b err=%b moves=%0d required 0,1,0,0,0,0",
                     floor_a, valid_a, up_a, dn_a, err_a, moves);
        end
    endtask

    task automatic test_up();
        step_a(3'b001, 3'd1, 1'b1, 1'b0, 6, "up_0_1");
        step_a(3'b011, 3'd2, 1'b1, 1'b0, 6, "up_1_2");
        step_a(3'b010, 3'd3, 1'b1, 1'b0, 6, "up_2_3");
    endtask

    task automatic test_down();
        step_a(3'b011, 3'd2, 1'b0, 1'b1, 6, "down_3_2");
    endtask

    task automatic test_glitch();
        int moves;
        moves = 0;
        g_a = 3'b111;
        repeat (3) @(negedge clk);
        g_a = 3'b011;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (moved_a === 1'b1) moves++;
        end
        n_vec++;
        if (floor_a !== 3'd2 || err_a !== 1'b0 || valid_a !== 1'b1 || moves != 0) begin
            n_err++;
            $display("FAIL glitch: floor=%0d err=%b valid=%b moves=%0d required 2,0,1,0",
                     floor_a, err_a, valid_a, moves);
        end
    endtask

    task automatic test_enable();
        int moves;
        moves = 0;
        en_a = 1'b0;
        g_a  = 3'b010;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (moved_a === 1'b1) moves++;
        end
        n_vec++;
        if (floor_a !== 3'd2 || moves != 0) begin
            n_err++;
            $display("FAIL enable_freeze: floor=%0d moves=%0d required 2,0", floor_a, moves);
        end
        en_a = 1'b1;
        step_a(3'b010, 3'd3, 1'b1, 1'b0, 0, "enable_resume");
        step_a(3'b011, 3'd2, 1'b0, 1'b1, 6, "down_back_2");
    endtask

    task automatic test_fault();
        int moves;
        moves = 0;
        g_a = 3'b110;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (moved_a === 1'b1) moves++;
        end
        n_vec++;
        if (err_a !== 1'b1 || valid_a !== 1'b0 || floor_a !== 3'd2 || moves != 0) begin
            n_err++;
            $display("FAIL skip_fault: err=%b valid=%b floor=%0d moves=%0d required 1,0,2,0",
                     err_a, valid_a, floor_a, moves);
        end
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        n_vec++;
        if ({err_a, valid_a, up_a, dn_a} !== 4'b0000) begin
            n_err++;
            $display("FAIL clear_err: {err,valid,up,dn} got %b required 0000",
                     {err_a, valid_a, up_a, dn_a});
        end
        @(negedge clk);
        n_vec++;
        if (valid_a !== 1'b1 || floor_a !== 3'd4 || moved_a !== 1'b0 || err_a !== 1'b0) begin
            n_err++;
            $display("FAIL reaccept: valid=%b floor=%0d moved=%b err=%b required 1,4,0,0",
                     valid_a, floor_a, moved_a, err_a);
        end
    endtask

    task automatic test_max5();
        rst_n_b = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++;
        if (valid_b !== 1'b1 || floor_b !== 3'd5 || err_b !== 1'b0) begin
            n_err++;
            $display("FAIL max5_load: valid=%b floor=%0d err=%b required 1,5,0", valid_b, floor_b, err_b);
        end
        g_b = 3'b101;
        repeat (8) @(negedge clk);
        n_vec++;
        if (err_b !== 1'b1 || valid_b !== 1'b0 || floor_b !== 3'd5 || moved_b !== 1'b0) begin
            n_err++;
            $display("FAIL max5_over: err=%b valid=%b floor=%0d moved=%b required 1,0,5,0",
                     err_b, valid_b, floor_b, moved_b);
        end
        rst_n_b = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({floor_b, valid_b, moved_b, up_b, dn_b, err_b} !== 8'b0) begin
            n_err++;
            $display("FAIL max5_reset_in_fault: got %b required 00000000",
                     {floor_b, valid_b, moved_b, up_b, dn_b, err_b});
        end
        rst_n_b = 1'b1;
        repeat (10) @(negedge clk);
        n_vec++;
        if (err_b !== 1'b1 || valid_b !== 1'b0 || floor_b !== 3'd0) begin
            n_err++;
            $display("FAIL max5_init_over: err=%b valid=%b floor=%0d required 1,0,0", err_b, valid_b, floor_b);
        end
    endtask

    initial begin
        test_reset();
        test_up();
        test_down();
        test_glitch();
        test_enable();
        test_fault();
        test_max5();
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
